// File: rtl/debouncer_multi_pkg.sv
// Shared constants and width helpers for the multi-channel debouncer.
// Board-level wrappers can pull the default timing values from here.
package debouncer_multi_pkg;

  localparam int DEF_TICK_DIV   = 5;
  localparam int DEF_SAMPLES    = 8;
  localparam int DEF_LONG_TICKS = 1000;

  // Per-channel observable state, bundled so the top can fan it out per port.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic long_press;
  } chan_out_t;

  // Width of a counter that runs 0..n-1 (never narrower than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold the value lt itself.
  function automatic int hold_w(input int lt);
    return (lt < 1) ? 1 : $clog2(lt + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer slice: synchroniser, agree filter, stable level, edge pulses
// and long-press hold counter. All filtering advances only on i_tick.
module debounce_channel
  import debouncer_multi_pkg::*;
#(
  parameter int   SAMPLES     = DEF_SAMPLES,
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0,
  parameter int   LONG_TICKS  = DEF_LONG_TICKS
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_tick,
  input  logic      i_raw,
  output chan_out_t o_chan
);

  localparam int            AW         = cnt_w(SAMPLES);
  localparam logic [AW-1:0] AGREE_LAST = AW'(SAMPLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [AW-1:0]          r_agree;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  logic                   w_accept;
  logic                   w_long;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_accept = i_tick && (w_s != r_level) && (r_agree == AGREE_LAST);

  // Edge pulses are registered alongside the level so both appear together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_agree <= '0;
      r_level <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= w_accept && w_s;
      r_fall <= w_accept && !w_s;
      if (i_tick) begin
        if ((w_s == r_level) || w_accept) r_agree <= '0;
        else                              r_agree <= r_agree + 1'b1;
        if (w_accept) r_level <= w_s;
      end
    end
  end

  generate
    if (LONG_TICKS > 0) begin : g_hold
      localparam int            HW       = hold_w(LONG_TICKS);
      localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

      logic [HW-1:0] r_hold;
      logic          r_long;

      // The tick that accepts a press or a release never counts as held time.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_hold <= '0;
          r_long <= 1'b0;
        end else begin
          r_long <= 1'b0;
          if (!r_level) begin
            r_hold <= '0;
          end else if (i_tick && !w_accept && (r_hold != HOLD_MAX)) begin
            r_hold <= r_hold + 1'b1;
            r_long <= (r_hold == (HOLD_MAX - 1'b1));
          end
        end
      end

      assign w_long = r_long;
    end else begin : g_no_hold
      assign w_long = 1'b0;
    end
  endgenerate

  assign o_chan = '{level: r_level, rise: r_rise, fall: r_fall, long_press: w_long};

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel button debouncer: one shared sample-tick counter feeding
// CHANNELS independent debounce_channel slices.
module debouncer_multi
  import debouncer_multi_pkg::*;
#(
  parameter int   CHANNELS    = 4,
  parameter int   TICK_DIV    = DEF_TICK_DIV,
  parameter int   SAMPLES     = DEF_SAMPLES,
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0,
  parameter int   LONG_TICKS  = DEF_LONG_TICKS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] button_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);

  localparam int            TW        = cnt_w(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]            r_tick_cnt;
  logic                     w_tick;
  chan_out_t [CHANNELS-1:0] w_chan;

  // enable low freezes the phase, so resuming continues the same sample period.
  assign w_tick = enable && (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset)       r_tick_cnt <= '0;
    else if (enable) r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
  end

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
        .SAMPLES    (SAMPLES),
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_LEVEL(RESET_LEVEL),
        .LONG_TICKS (LONG_TICKS)
      ) u_ch (
        .clk   (clk),
        .reset (reset),
        .i_tick(w_tick),
        .i_raw (button_in[g]),
        .o_chan(w_chan[g])
      );

      assign button_out[g] = w_chan[g].level;
      assign rise[g]       = w_chan[g].rise;
      assign fall[g]       = w_chan[g].fall;
      assign long_press[g] = w_chan[g].long_press;
    end
  endgenerate

endmodule
